decode_stage_modrm_sib_seq: RTL
===============================

// Module: decode_stage_modrm_sib_seq
// PURPOSE
//  Byte-serial addressing-mode decoder: consumes ModR/M, optional SIB and 0/1/2/4 displacement bytes
//  from the prefetch byte queue and emits one complete effective-address descriptor per operand.
//  Supports 32-bit and (parametrised) 16-bit address-size forms. Sits between opcode decode and the
//  address-generation unit; valid/ready on both sides.
// PARAMETERS
//  SUPPORT_ADDR16  1   1: honour i_addr32=0 (16-bit forms); 0: i_addr32 ignored, always 32-bit forms
//  DISP_W          32  width of o_disp (>=16); displacement sign-extended to this width
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_rst_n        in   1       reset, asynchronous, active-low
//  i_flush        in   1       synchronous abort of current operand
//  i_addr32       in   1       address size, sampled with the ModR/M byte
//  i_byte_valid   in   1       queue byte valid
//  i_byte         in   8       queue byte
//  o_byte_ready   out  1       byte consumed this cycle when valid&ready
//  o_ea_valid     out  1       descriptor valid; held stable until accepted
//  i_ea_ready     in   1       AGU accepts descriptor
//  o_mod/o_reg/o_rm out 2/3/3  ModR/M fields
//  o_is_reg       out  1       mod==11: register operand, no memory access
//  o_scale        out  2       SIB ss (00 when no SIB)
//  o_index_present/o_index_idx out 1/3   index reg (32-bit GPR numbering)
//  o_base_present/o_base_idx   out 1/3   base reg (32-bit GPR numbering)
//  o_disp_len     out  3       displacement bytes: 0,1,2,4
//  o_disp         out  DISP_W  sign-extended displacement
//  o_length       out  3       bytes consumed: 1..6
//  o_ea_undefined out  1       SIB index==100 with ss!=00
// BEHAVIOUR
//  Reset: state S_MODRM; o_ea_valid=0, o_byte_ready=0 until reset released; all descriptor regs 0.
//  States: S_MODRM -> (mod==11 | no SIB, no disp) S_OUT; (SIB needed) S_SIB; (disp>0) S_DISP.
//   S_SIB -> S_DISP if disp>0 else S_OUT. S_DISP: count down bytes, last byte -> S_OUT.
//   S_OUT: o_ea_valid=1; on i_ea_ready -> S_MODRM. o_byte_ready=1 only in S_MODRM/S_SIB/S_DISP.
//  Latency: descriptor valid the cycle after the last byte is consumed (mod==11: 1 cycle after ModR/M).
//  No bubble: next ModR/M accepted the cycle after descriptor handshake.
//  32-bit: rm==100 & mod!=11 -> SIB. Disp: mod01=1; mod10=4; mod00 & rm==101 (no SIB) =4, no base;
//   mod00 & SIB base==101 =4, base absent; index absent when SIB index==100.
//  16-bit: no SIB. mod01=1; mod10=2; mod00 & rm==110 =2, no base/index. rm map: 000 BX+SI,
//   001 BX+DI, 010 BP+SI, 011 BP+DI, 100 SI, 101 DI, 110 BP, 111 BX (indices 3,5,6,7).
//  Displacement bytes little-endian; disp8/disp16 sign-extended to DISP_W.
//  Flush: S_MODRM next cycle, o_ea_valid drops, partial descriptor discarded; o_byte_ready forced 0
//   in the flush cycle (flush wins over simultaneous byte and over simultaneous ea_ready).
//  Byte gaps (i_byte_valid=0) stall the FSM in place; no timeout.
//  Async reset mid-operand: immediate return to reset state, no descriptor emitted.
// CONFIGURATION
//  DECODE_SEG_DEFAULT_EN defined: extra output o_seg_ss (1 bit, reset 0) =1 when base present and base
//   is ESP/EBP (32-bit) or rm form uses BP (16-bit); else 0. Undefined: port and logic absent.
// STRUCTURE
//  Package w80386_decode_pkg: state enum (S_MODRM,S_SIB,S_DISP,S_OUT), disp-length constants
//   (0/1/2/4), GPR index constants (EAX..EDI), descriptor packed struct.
//  Sub-module decode_modrm_classify: combinational, ModR/M(+SIB)+addr32 -> sib_needed, disp_len,
//   base/index present+idx; instantiated once, fed by live byte in S_MODRM/S_SIB.
// TESTING
//  32-bit 8B 44 24 08 (mod01 rm100, SIB 24): index absent, base 4, disp 0x00000008, length 3.
//  32-bit ModR/M 05 + disp 78 56 34 12: base absent, disp 0x12345678, disp_len 4, length 5.
//  16-bit ModR/M 46 + disp FE: base 5 (BP), index absent, disp 0xFFFFFFFE, length 2, o_seg_ss=1 when en.
//  ModR/M C3: o_is_reg=1, descriptor valid 1 cycle later; i_ea_ready low 3 cycles -> held, no bytes taken.
//  SIB 64 (ss01 index100): o_ea_undefined=1; i_flush mid-disp -> no descriptor, next ModR/M decodes clean.
//  Random byte gaps + back-to-back operands vs. reference model: identical descriptors, zero bubbles.

Source files
------------

// File: rtl/w80386_decode_pkg.sv
// Shared types and constants for the ModR/M + SIB addressing-mode decoder.
package w80386_decode_pkg;

  typedef enum logic [1:0] {
    S_MODRM = 2'd0,
    S_SIB   = 2'd1,
    S_DISP  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam logic [2:0] DISP_LEN_0 = 3'd0;
  localparam logic [2:0] DISP_LEN_1 = 3'd1;
  localparam logic [2:0] DISP_LEN_2 = 3'd2;
  localparam logic [2:0] DISP_LEN_4 = 3'd4;

  localparam logic [2:0] GPR_EAX = 3'd0;
  localparam logic [2:0] GPR_ECX = 3'd1;
  localparam logic [2:0] GPR_EDX = 3'd2;
  localparam logic [2:0] GPR_EBX = 3'd3;
  localparam logic [2:0] GPR_ESP = 3'd4;
  localparam logic [2:0] GPR_EBP = 3'd5;
  localparam logic [2:0] GPR_ESI = 3'd6;
  localparam logic [2:0] GPR_EDI = 3'd7;

  // Effective-address descriptor minus the displacement value (width is a top parameter).
  typedef struct packed {
    logic [1:0] mod;
    logic [2:0] reg_f;
    logic [2:0] rm;
    logic       is_reg;
    logic       addr32;
    logic [1:0] scale;
    logic       index_present;
    logic [2:0] index_idx;
    logic       base_present;
    logic [2:0] base_idx;
    logic [2:0] disp_len;
    logic [2:0] length;
    logic       undefined;
  } ea_desc_t;

endpackage

// File: rtl/decode_modrm_classify.sv
// Combinational ModR/M(+SIB) classifier: SIB need, displacement length and base/index registers.
module decode_modrm_classify
  import w80386_decode_pkg::*;
(
  input  logic [1:0] i_mod,
  input  logic [2:0] i_rm,
  input  logic [7:0] i_sib,
  input  logic       i_addr32,
  output logic       o_sib_needed,
  output logic [2:0] o_disp_len,
  output logic [1:0] o_scale,
  output logic       o_index_present,
  output logic [2:0] o_index_idx,
  output logic       o_base_present,
  output logic [2:0] o_base_idx,
  output logic       o_undefined
);

  logic [1:0] sib_ss;
  logic [2:0] sib_index;
  logic [2:0] sib_base;

  assign sib_ss    = i_sib[7:6];
  assign sib_index = i_sib[5:3];
  assign sib_base  = i_sib[2:0];

  always_comb begin
    o_sib_needed    = 1'b0;
    o_disp_len      = DISP_LEN_0;
    o_scale         = 2'b00;
    o_index_present = 1'b0;
    o_index_idx     = GPR_EAX;
    o_base_present  = 1'b0;
    o_base_idx      = GPR_EAX;
    o_undefined     = 1'b0;
    if (i_mod != 2'b11) begin
      if (i_addr32) begin
        case (i_mod)
          2'b01:   o_disp_len = DISP_LEN_1;
          2'b10:   o_disp_len = DISP_LEN_4;
          default: o_disp_len = DISP_LEN_0;
        endcase
        if (i_rm == GPR_ESP) begin
          o_sib_needed    = 1'b1;
          o_scale         = sib_ss;
          o_index_present = (sib_index != GPR_ESP);
          o_index_idx     = sib_index;
          o_undefined     = (sib_index == GPR_ESP) && (sib_ss != 2'b00);
          // mod 00 with SIB base EBP means disp32 and no base register
          if ((i_mod == 2'b00) && (sib_base == GPR_EBP)) begin
            o_disp_len = DISP_LEN_4;
          end else begin
            o_base_present = 1'b1;
            o_base_idx     = sib_base;
          end
        end else if ((i_mod == 2'b00) && (i_rm == GPR_EBP)) begin
          o_disp_len = DISP_LEN_4;
        end else begin
          o_base_present = 1'b1;
          o_base_idx     = i_rm;
        end
      end else begin
        case (i_mod)
          2'b01:   o_disp_len = DISP_LEN_1;
          2'b10:   o_disp_len = DISP_LEN_2;
          default: o_disp_len = DISP_LEN_0;
        endcase
        if ((i_mod == 2'b00) && (i_rm == 3'b110)) begin
          o_disp_len = DISP_LEN_2;
        end else begin
          // 16-bit forms: BX/BP act as base, SI/DI as index when paired
          o_base_present = 1'b1;
          case (i_rm)
            3'b000: begin o_base_idx = GPR_EBX; o_index_present = 1'b1; o_index_idx = GPR_ESI; end
            3'b001: begin o_base_idx = GPR_EBX; o_index_present = 1'b1; o_index_idx = GPR_EDI; end
            3'b010: begin o_base_idx = GPR_EBP; o_index_present = 1'b1; o_index_idx = GPR_ESI; end
            3'b011: begin o_base_idx = GPR_EBP; o_index_present = 1'b1; o_index_idx = GPR_EDI; end
            3'b100: o_base_idx = GPR_ESI;
            3'b101: o_base_idx = GPR_EDI;
            3'b110: o_base_idx = GPR_EBP;
            default: o_base_idx = GPR_EBX;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/decode_stage_modrm_sib_seq.sv
// Byte-serial ModR/M/SIB/displacement sequencer emitting one EA descriptor per operand.
// Optional o_seg_ss output enabled by defining DECODE_SEG_DEFAULT_EN.
module decode_stage_modrm_sib_seq
  import w80386_decode_pkg::*;
#(
  parameter int unsigned SUPPORT_ADDR16 = 1,
  parameter int unsigned DISP_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_addr32,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic              o_ea_valid,
  input  logic              i_ea_ready,
  output logic [1:0]        o_mod,
  output logic [2:0]        o_reg,
  output logic [2:0]        o_rm,
  output logic              o_is_reg,
  output logic [1:0]        o_scale,
  output logic              o_index_present,
  output logic [2:0]        o_index_idx,
  output logic              o_base_present,
  output logic [2:0]        o_base_idx,
  output logic [2:0]        o_disp_len,
  output logic [DISP_W-1:0] o_disp,
  output logic [2:0]        o_length,
  output logic              o_ea_undefined
`ifdef DECODE_SEG_DEFAULT_EN
  ,output logic             o_seg_ss
`endif
);

  state_e             state_q, state_d;
  ea_desc_t           desc_q, desc_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         didx_q, didx_d;
  logic               ea_valid_q, ea_valid_d;
  logic               byte_rdy_q, byte_rdy_d;

  logic               byte_fire;
  logic               a32_live;
  logic [1:0]         cls_mod;
  logic [2:0]         cls_rm;
  logic               cls_a32;
  logic               cls_sib_needed;
  logic [2:0]         cls_disp_len;
  logic [1:0]         cls_scale;
  logic               cls_index_present;
  logic [2:0]         cls_index_idx;
  logic               cls_base_present;
  logic [2:0]         cls_base_idx;
  logic               cls_undefined;
  logic [4:0]         disp_shamt;
  logic [DISP_W-1:0]  disp_byte_sx;
  logic [DISP_W-1:0]  disp_keep_mask;

  assign o_byte_ready = byte_rdy_q && !i_flush;
  assign byte_fire    = i_byte_valid && o_byte_ready;
  assign a32_live     = (SUPPORT_ADDR16 == 0) || i_addr32;

  // Classifier sees the live ModR/M in S_MODRM, the latched one (plus live SIB) afterwards
  assign cls_mod = (state_q == S_MODRM) ? i_byte[7:6] : desc_q.mod;
  assign cls_rm  = (state_q == S_MODRM) ? i_byte[2:0] : desc_q.rm;
  assign cls_a32 = (state_q == S_MODRM) ? a32_live    : desc_q.addr32;

  decode_modrm_classify u_classify (
    .i_mod           (cls_mod),
    .i_rm            (cls_rm),
    .i_sib           (i_byte),
    .i_addr32        (cls_a32),
    .o_sib_needed    (cls_sib_needed),
    .o_disp_len      (cls_disp_len),
    .o_scale         (cls_scale),
    .o_index_present (cls_index_present),
    .o_index_idx     (cls_index_idx),
    .o_base_present  (cls_base_present),
    .o_base_idx      (cls_base_idx),
    .o_undefined     (cls_undefined)
  );

  // Each little-endian byte lands at its slot and sign-fills everything above it
  assign disp_shamt     = {didx_q, 3'b000};
  assign disp_byte_sx   = DISP_W'($signed(i_byte)) << disp_shamt;
  assign disp_keep_mask = (DISP_W'(1) << disp_shamt) - DISP_W'(1);

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    didx_d  = didx_q;
    if (i_flush) begin
      state_d = S_MODRM;
      desc_d  = '0;
      disp_d  = '0;
      cnt_d   = 3'd0;
      didx_d  = 2'd0;
    end else begin
      case (state_q)
        S_MODRM: begin
          if (byte_fire) begin
            desc_d          = '0;
            disp_d          = '0;
            desc_d.mod      = i_byte[7:6];
            desc_d.reg_f    = i_byte[5:3];
            desc_d.rm       = i_byte[2:0];
            desc_d.is_reg   = (i_byte[7:6] == 2'b11);
            desc_d.addr32   = a32_live;
            desc_d.length   = 3'd1;
            desc_d.disp_len = cls_disp_len;
            cnt_d           = cls_disp_len;
            didx_d          = 2'd0;
            if (!cls_sib_needed) begin
              desc_d.index_present = cls_index_present;
              desc_d.index_idx     = cls_index_idx;
              desc_d.base_present  = cls_base_present;
              desc_d.base_idx      = cls_base_idx;
            end
            if (desc_d.is_reg)                  state_d = S_OUT;
            else if (cls_sib_needed)            state_d = S_SIB;
            else if (cls_disp_len != DISP_LEN_0) state_d = S_DISP;
            else                                state_d = S_OUT;
          end
        end
        S_SIB: begin
          if (byte_fire) begin
            desc_d.scale         = cls_scale;
            desc_d.index_present = cls_index_present;
            desc_d.index_idx     = cls_index_idx;
            desc_d.base_present  = cls_base_present;
            desc_d.base_idx      = cls_base_idx;
            desc_d.undefined     = cls_undefined;
            desc_d.disp_len      = cls_disp_len;
            desc_d.length        = 3'd2;
            cnt_d                = cls_disp_len;
            state_d = (cls_disp_len != DISP_LEN_0) ? S_DISP : S_OUT;
          end
        end
        S_DISP: begin
          if (byte_fire) begin
            disp_d        = (disp_q & disp_keep_mask) | disp_byte_sx;
            desc_d.length = desc_q.length + 3'd1;
            didx_d        = didx_q + 2'd1;
            cnt_d         = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (i_ea_ready) state_d = S_MODRM;
        end
        default: state_d = S_MODRM;
      endcase
    end
    ea_valid_d = (state_d == S_OUT);
    byte_rdy_d = (state_d != S_OUT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_MODRM;
      desc_q     <= '0;
      disp_q     <= '0;
      cnt_q      <= 3'd0;
      didx_q     <= 2'd0;
      ea_valid_q <= 1'b0;
      byte_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      didx_q     <= didx_d;
      ea_valid_q <= ea_valid_d;
      byte_rdy_q <= byte_rdy_d;
    end
  end

`ifdef DECODE_SEG_DEFAULT_EN
  logic seg_ss_q, seg_ss_d;

  // EBP/ESP-based addressing defaults to the stack segment
  assign seg_ss_d = desc_d.base_present &&
                    ((desc_d.base_idx == GPR_EBP) ||
                     (desc_d.addr32 && (desc_d.base_idx == GPR_ESP)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) seg_ss_q <= 1'b0;
    else          seg_ss_q <= seg_ss_d;
  end

  assign o_seg_ss = seg_ss_q;
`endif

  assign o_ea_valid      = ea_valid_q;
  assign o_mod           = desc_q.mod;
  assign o_reg           = desc_q.reg_f;
  assign o_rm            = desc_q.rm;
  assign o_is_reg        = desc_q.is_reg;
  assign o_scale         = desc_q.scale;
  assign o_index_present = desc_q.index_present;
  assign o_index_idx     = desc_q.index_idx;
  assign o_base_present  = desc_q.base_present;
  assign o_base_idx      = desc_q.base_idx;
  assign o_disp_len      = desc_q.disp_len;
  assign o_disp          = disp_q;
  assign o_length        = desc_q.length;
  assign o_ea_undefined  = desc_q.undefined;

endmodule
